// File: rtl/req_pending_pkg.sv
// Shared sizing for the pending-request controller and its arbiter.
// Both sides import these so the port count and counter width stay in step.
package req_pending_pkg;
  localparam int NUM_PORTS = 5;
  localparam int CNT_W     = 3;
  localparam int MAX_PEND  = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = cnt_t'(MAX_PEND);
endpackage

// File: rtl/req_pending_ctrl_if.sv
// Bundle between the requester/arbiter side (master) and the pending controller (slave).
// Handshake: push_i bits are one-cycle pulses that each add one pending request;
// req_o[i] is held while port i has a request not covered by this cycle's grant;
// gnt_i is the arbiter's registered answer to req_o and consumes one request per bit.
interface req_pending_ctrl_if;
  import req_pending_pkg::*;

  logic [NUM_PORTS-1:0]            push_i;
  logic                            flush_i;
  logic                            clr_err_i;
  logic [NUM_PORTS-1:0]            gnt_i;
  logic [NUM_PORTS-1:0]            req_o;
  logic [NUM_PORTS-1:0]            full_o;
  logic                            ovf_o;
  logic                            err_o;
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_dbg;

  modport master (
    output push_i, flush_i, clr_err_i, gnt_i,
    input  req_o, full_o, ovf_o, err_o, cnt_dbg
  );

  modport slave (
    input  push_i, flush_i, clr_err_i, gnt_i,
    output req_o, full_o, ovf_o, err_o, cnt_dbg
  );
endinterface

// File: rtl/req_pending_slot.sv
// One port's saturating pending counter with req/full decode and
// single-cycle overflow / spurious-grant pulses for the top to collect.
module req_pending_slot
  import req_pending_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  logic gnt,
  input  logic flush,
  output cnt_t cnt,
  output logic req,
  output logic full,
  output logic ovf_pulse,
  output logic spur_pulse
);

  cnt_t cnt_q;
  cnt_t cnt_d;
  logic is_zero;
  logic is_max;

  assign is_zero = (cnt_q == '0);
  assign is_max  = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d      = cnt_q;
    ovf_pulse  = 1'b0;
    spur_pulse = 1'b0;
    if (flush) begin
      cnt_d = '0;
    end else begin
      unique case ({push, gnt})
        2'b10: begin
          if (is_max) ovf_pulse = 1'b1;
          else        cnt_d     = cnt_q + cnt_t'(1);
        end
        2'b01: begin
          if (is_zero) spur_pulse = 1'b1;
          else         cnt_d      = cnt_q - cnt_t'(1);
        end
        2'b11: begin
          // A grant on an empty port is spurious, but the push still lands.
          if (is_zero) begin
            spur_pulse = 1'b1;
            cnt_d      = cnt_t'(1);
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Request only when something remains after this cycle's grant; push is ignored here.
  assign req  = (cnt_q > cnt_t'(gnt));
  assign full = is_max;
  assign cnt  = cnt_q;

endmodule

// File: rtl/req_pending_ctrl.sv
// Per-port pending-request counters feeding a registered fixed-priority arbiter,
// with sticky overflow and illegal-grant flags.
module req_pending_ctrl
  import req_pending_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  req_pending_ctrl_if.slave    bus
);

  logic [NUM_PORTS-1:0] ovf_pulse;
  logic [NUM_PORTS-1:0] spur_pulse;
  logic                 multi_hot;
  logic                 ovf_set;
  logic                 err_set;
  logic                 ovf_q;
  logic                 err_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    cnt_t slot_cnt;

    req_pending_slot u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push       (bus.push_i[i]),
      .gnt        (bus.gnt_i[i]),
      .flush      (bus.flush_i),
      .cnt        (slot_cnt),
      .req        (bus.req_o[i]),
      .full       (bus.full_o[i]),
      .ovf_pulse  (ovf_pulse[i]),
      .spur_pulse (spur_pulse[i])
    );

    assign bus.cnt_dbg[i] = slot_cnt;
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hot = ((bus.gnt_i & (bus.gnt_i - NUM_PORTS'(1))) != '0);

  // Slot pulses are already masked by flush; the multi-hot check is masked here.
  assign ovf_set = |ovf_pulse;
  assign err_set = (|spur_pulse) | (multi_hot & ~bus.flush_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (ovf_set)             ovf_q <= 1'b1;
      else if (bus.clr_err_i)  ovf_q <= 1'b0;
      if (err_set)             err_q <= 1'b1;
      else if (bus.clr_err_i)  err_q <= 1'b0;
    end
  end

  assign bus.ovf_o = ovf_q;
  assign bus.err_o = err_q;

endmodule

// File: tb/tb_req_pending_ctrl.sv
// Directed bench for req_pending_ctrl: reset, single/back-to-back requests,
// saturation, illegal grants, simultaneous events, flush and mid-run reset.
module tb_req_pending_ctrl;
  import req_pending_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  req_pending_ctrl_if bus ();

  req_pending_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.push_i    = '0;
    bus.gnt_i     = '0;
    bus.flush_i   = 1'b0;
    bus.clr_err_i = 1'b0;
  endtask

  task automatic clean_state();
    idle_inputs();
    bus.flush_i   = 1'b1;
    bus.clr_err_i = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.push_i = 5'b11111;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus.req_o !== 5'b00000) begin
        bad++; $display("FAIL reset_req cyc=%0d got=%b exp=00000", c, bus.req_o);
      end
      total++;
      if (bus.full_o !== 5'b00000) begin
        bad++; $display("FAIL reset_full cyc=%0d got=%b exp=00000", c, bus.full_o);
      end
      total++;
      if (bus.ovf_o !== 1'b0) begin
        bad++; $display("FAIL reset_ovf cyc=%0d got=%b exp=0", c, bus.ovf_o);
      end
      total++;
      if (bus.err_o !== 1'b0) begin
        bad++; $display("FAIL reset_err cyc=%0d got=%b exp=0", c, bus.err_o);
      end
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.push_i = 5'b00100;
    tick();
    bus.push_i = '0;
    #1;
    total++;
    if (bus.req_o !== 5'b00100) begin
      bad++; $display("FAIL single_req got=%b exp=00100", bus.req_o);
    end
    bus.gnt_i = 5'b00100;
    #1;
    total++;
    if (bus.req_o !== 5'b00000) begin
      bad++; $display("FAIL single_req_during_gnt got=%b exp=00000", bus.req_o);
    end
    tick();
    bus.gnt_i = '0;
    #1;
    total++;
    if (bus.cnt_dbg[2] !== 3'd0) begin
      bad++; $display("FAIL single_cnt2 got=%0d exp=0", bus.cnt_dbg[2]);
    end
    total++;
    if (bus.err_o !== 1'b0) begin
      bad++; $display("FAIL single_err got=%b exp=0", bus.err_o);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_req [3];
    exp_req = '{1'b1, 1'b1, 1'b0};
    bus.push_i = 5'b00001;
    repeat (3) tick();
    bus.push_i = '0;
    #1;
    total++;
    if (bus.cnt_dbg[0] !== 3'd3) begin
      bad++; $display("FAIL b2b_cnt_after_push got=%0d exp=3", bus.cnt_dbg[0]);
    end
    bus.gnt_i = 5'b00001;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.req_o[0] !== exp_req[c]) begin
        bad++; $display("FAIL b2b_req0 gnt_cyc=%0d got=%b exp=%b", c, bus.req_o[0], exp_req[c]);
      end
      tick();
    end
    bus.gnt_i = '0;
    #1;
    total++;
    if (bus.cnt_dbg[0] !== 3'd0) begin
      bad++; $display("FAIL b2b_cnt_end got=%0d exp=0", bus.cnt_dbg[0]);
    end
    total++;
    if (bus.err_o !== 1'b0) begin
      bad++; $display("FAIL b2b_err got=%b exp=0", bus.err_o);
    end
  endtask

  task automatic test_overflow();
    bus.push_i = 5'b00010;
    repeat (6) tick();
    total++;
    if (bus.full_o !== 5'b00000) begin
      bad++; $display("FAIL ovf_full_after6 got=%b exp=00000", bus.full_o);
    end
    tick();
    total++;
    if (bus.full_o !== 5'b00010) begin
      bad++; $display("FAIL ovf_full_after7 got=%b exp=00010", bus.full_o);
    end
    total++;
    if (bus.ovf_o !== 1'b0) begin
      bad++; $display("FAIL ovf_flag_after7 got=%b exp=0", bus.ovf_o);
    end
    tick();
    bus.push_i = '0;
    total++;
    if (bus.ovf_o !== 1'b1) begin
      bad++; $display("FAIL ovf_flag_after8 got=%b exp=1", bus.ovf_o);
    end
    total++;
    if (bus.cnt_dbg[1] !== 3'd7) begin
      bad++; $display("FAIL ovf_cnt1 got=%0d exp=7", bus.cnt_dbg[1]);
    end
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    total++;
    if (bus.ovf_o !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b exp=0", bus.ovf_o);
    end
    total++;
    if (bus.cnt_dbg[1] !== 3'd7) begin
      bad++; $display("FAIL ovf_cnt1_kept got=%0d exp=7", bus.cnt_dbg[1]);
    end
    clean_state();
  endtask

  task automatic test_illegal_grants();
    bus.gnt_i = 5'b01000;
    tick();
    bus.gnt_i = '0;
    total++;
    if (bus.err_o !== 1'b1) begin
      bad++; $display("FAIL spur_err got=%b exp=1", bus.err_o);
    end
    total++;
    if (bus.cnt_dbg[3] !== 3'd0) begin
      bad++; $display("FAIL spur_cnt3 got=%0d exp=0", bus.cnt_dbg[3]);
    end
    // clear and a new spurious grant in the same cycle: flag must stay set
    bus.clr_err_i = 1'b1;
    bus.gnt_i     = 5'b01000;
    tick();
    idle_inputs();
    total++;
    if (bus.err_o !== 1'b1) begin
      bad++; $display("FAIL set_beats_clear got=%b exp=1", bus.err_o);
    end
    bus.clr_err_i = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (bus.err_o !== 1'b0) begin
      bad++; $display("FAIL err_clear got=%b exp=0", bus.err_o);
    end
    bus.push_i = 5'b00011;
    tick();
    bus.push_i = '0;
    bus.gnt_i  = 5'b00011;
    tick();
    bus.gnt_i = '0;
    total++;
    if (bus.err_o !== 1'b1) begin
      bad++; $display("FAIL multihot_err got=%b exp=1", bus.err_o);
    end
    total++;
    if (bus.cnt_dbg[0] !== 3'd0 || bus.cnt_dbg[1] !== 3'd0) begin
      bad++; $display("FAIL multihot_cnt got=%0d,%0d exp=0,0", bus.cnt_dbg[0], bus.cnt_dbg[1]);
    end
    // spurious grant with simultaneous push lands at 1 and flags an error
    clean_state();
    bus.push_i = 5'b00100;
    bus.gnt_i  = 5'b00100;
    tick();
    idle_inputs();
    total++;
    if (bus.cnt_dbg[2] !== 3'd1 || bus.err_o !== 1'b1) begin
      bad++; $display("FAIL spur_with_push cnt=%0d err=%b exp cnt=1 err=1", bus.cnt_dbg[2], bus.err_o);
    end
    clean_state();
  endtask

  task automatic test_simultaneous();
    bus.push_i = 5'b10000;
    repeat (7) tick();
    bus.gnt_i = 5'b10000;
    tick();
    idle_inputs();
    total++;
    if (bus.cnt_dbg[4] !== 3'd7) begin
      bad++; $display("FAIL simul_cnt4 got=%0d exp=7", bus.cnt_dbg[4]);
    end
    total++;
    if (bus.ovf_o !== 1'b0 || bus.err_o !== 1'b0) begin
      bad++; $display("FAIL simul_flags ovf=%b err=%b exp=0,0", bus.ovf_o, bus.err_o);
    end
    // flush with pushes everywhere (port 4 full) and a multi-hot grant
    bus.flush_i = 1'b1;
    bus.push_i  = 5'b11111;
    bus.gnt_i   = 5'b10001;
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.cnt_dbg !== '0) begin
      bad++; $display("FAIL flush_cnt got=%h exp=0", bus.cnt_dbg);
    end
    total++;
    if (bus.req_o !== 5'b00000 || bus.full_o !== 5'b00000) begin
      bad++; $display("FAIL flush_req_full req=%b full=%b exp=00000", bus.req_o, bus.full_o);
    end
    total++;
    if (bus.ovf_o !== 1'b0 || bus.err_o !== 1'b0) begin
      bad++; $display("FAIL flush_flags ovf=%b err=%b exp=0,0", bus.ovf_o, bus.err_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.push_i = 5'b00101;
    repeat (2) tick();
    bus.push_i = '0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.req_o !== 5'b00000 || bus.cnt_dbg !== '0) begin
      bad++; $display("FAIL midreset_async req=%b cnt=%h exp=00000,0", bus.req_o, bus.cnt_dbg);
    end
    tick();
    rst_n = 1'b1;
    bus.push_i = 5'b00001;
    tick();
    bus.push_i = '0;
    total++;
    if (bus.cnt_dbg[0] !== 3'd1 || bus.req_o !== 5'b00001) begin
      bad++; $display("FAIL midreset_first_push cnt0=%0d req=%b exp=1,00001", bus.cnt_dbg[0], bus.req_o);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_illegal_grants();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
